// File: rtl/fir_xifu_ctrl.sv
// fir_xifu_ctrl
//   Control block for the FIR XIFU pipeline. It tracks each offloaded
//   instruction by XIF ID from issue through commit/kill to writeback. It
//   keeps a register scoreboard that stalls issue on RAW/WAW hazards. It
//   sequences the single outstanding LSU transaction and drives the pipeline
//   advance enable.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous flush of all state (highest priority)
//   issue_*                XIF issue offer; issue_ready_o is the handshake
//   commit_*               XIF commit/kill strobe
//   commit_o, kill_o       per-ID committed / killed flags (same-cycle bypass)
//   mem_valid_i/ready_i    EX memory request and LSU grant
//   mem_result_*           LSU response
//   wb_valid_i, wb_id_i    WB retire
//   ex_ready_o             pipeline advance enable for EX
module fir_xifu_ctrl #(
  parameter int NUM_ID   = 4,
  parameter int NUM_XREG = 32,
  localparam int ID_W    = (NUM_ID > 1) ? $clog2(NUM_ID) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              issue_valid_i,
  input  logic [ID_W-1:0]   issue_id_i,
  input  logic [4:0]        issue_rs1_i,
  input  logic [4:0]        issue_rs2_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              issue_rd_we_i,
  input  logic              issue_mem_i,
  output logic              issue_ready_o,
  input  logic              commit_valid_i,
  input  logic [ID_W-1:0]   commit_id_i,
  input  logic              commit_kill_i,
  output logic [NUM_ID-1:0] commit_o,
  output logic [NUM_ID-1:0] kill_o,
  input  logic              mem_valid_i,
  input  logic              mem_ready_i,
  input  logic              mem_result_valid_i,
  input  logic [ID_W-1:0]   mem_result_id_i,
  input  logic              wb_valid_i,
  input  logic [ID_W-1:0]   wb_id_i,
  output logic              ex_ready_o
);

  typedef enum logic [1:0] {S_FREE, S_ISSUED, S_COMMITTED, S_KILLED} slot_e;
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_RESP} mem_e;

  slot_e               slot_q [NUM_ID];
  slot_e               slot_d [NUM_ID];
  logic [NUM_XREG-1:0] busy_q, busy_d;
  logic [ID_W-1:0]     owner_q [NUM_XREG];
  mem_e                mem_q, mem_d;
  // mem_next_id_q: last memory instruction issued (the next request in EX).
  // mem_out_id_q: instruction owning the transaction currently in flight.
  logic [ID_W-1:0]     mem_next_id_q, mem_out_id_q;

  logic            issue_hs, commit_ev, kill_ev, resp_match, clr_reg, pending;
  logic [ID_W-1:0] own;

  assign commit_ev  = commit_valid_i & ~commit_kill_i;
  assign kill_ev    = commit_valid_i & commit_kill_i;
  assign resp_match = (mem_q == M_RESP) & mem_result_valid_i
                    & (mem_result_id_i == mem_out_id_q);

  assign issue_ready_o = issue_valid_i & (slot_q[issue_id_i] == S_FREE)
                       & ~busy_q[issue_rs1_i] & ~busy_q[issue_rs2_i]
                       & ~(issue_rd_we_i & busy_q[issue_rd_i])
                       & ex_ready_o & ~clear_i;
  assign issue_hs = issue_ready_o;

  always_comb begin
    for (int i = 0; i < NUM_ID; i++) begin
      commit_o[i] = (slot_q[i] == S_COMMITTED) | (commit_ev & (commit_id_i == ID_W'(i)));
      kill_o[i]   = (slot_q[i] == S_KILLED)    | (kill_ev   & (commit_id_i == ID_W'(i)));
    end
  end

  // Memory FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mem_q <= M_IDLE;
    else         mem_q <= mem_d;
  end

  // Memory FSM: next state
  always_comb begin
    mem_d = mem_q;
    unique case (mem_q)
      M_IDLE:  if (mem_valid_i) mem_d = mem_ready_i ? M_RESP : M_REQ;
      M_REQ:   if (mem_ready_i) mem_d = M_RESP;
      M_RESP:  if (resp_match)  mem_d = M_IDLE;
      default: mem_d = M_IDLE;
    endcase
    if (clear_i) mem_d = M_IDLE;
  end

  // Memory FSM: outputs
  always_comb begin
    ex_ready_o = 1'b1;
    unique case (mem_q)
      M_IDLE:  ex_ready_o = ~(mem_valid_i & ~mem_ready_i);
      M_REQ:   ex_ready_o = 1'b0;
      M_RESP:  ex_ready_o = resp_match;
      default: ex_ready_o = 1'b1;
    endcase
  end

  // Slot next state; retire outranks a same-cycle commit
  always_comb begin
    slot_d  = slot_q;
    pending = 1'b0;
    for (int i = 0; i < NUM_ID; i++) begin
      // A killed load/store holds its slot until its response returns
      pending = (mem_q != M_IDLE) & (mem_out_id_q == ID_W'(i)) & ~resp_match;
      unique case (slot_q[i])
        S_FREE:      if (issue_hs & (issue_id_i == ID_W'(i))) slot_d[i] = S_ISSUED;
        S_ISSUED: begin
          if (kill_ev & (commit_id_i == ID_W'(i)))        slot_d[i] = S_KILLED;
          else if (commit_ev & (commit_id_i == ID_W'(i))) slot_d[i] = S_COMMITTED;
        end
        S_KILLED:    if (!pending) slot_d[i] = S_FREE;
        default:     slot_d[i] = slot_q[i];
      endcase
      if (wb_valid_i & (wb_id_i == ID_W'(i))
          & ((slot_q[i] == S_ISSUED) | (slot_q[i] == S_COMMITTED)))
        slot_d[i] = S_FREE;
      if (clear_i) slot_d[i] = S_FREE;
    end
  end

  // Scoreboard next state. Set needs a free rd and clear needs a busy one,
  // so both never hit the same register in one cycle.
  always_comb begin
    busy_d  = busy_q;
    own     = '0;
    clr_reg = 1'b0;
    for (int r = 0; r < NUM_XREG; r++) begin
      own     = owner_q[r];
      clr_reg = (wb_valid_i & (wb_id_i == own)
                 & ((slot_q[own] == S_ISSUED) | (slot_q[own] == S_COMMITTED)))
              | (kill_ev & (commit_id_i == own) & (slot_q[own] == S_ISSUED));
      if (busy_q[r] & clr_reg) busy_d[r] = 1'b0;
    end
    if (issue_hs & issue_rd_we_i) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
    if (clear_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_ID; i++) slot_q[i] <= S_FREE;
    end else begin
      busy_q <= busy_d;
      slot_q <= slot_d;
    end
  end

  // Owner and memory IDs are only read while qualified by busy/FSM state
  always_ff @(posedge clk_i) begin
    if (issue_hs & issue_rd_we_i) owner_q[issue_rd_i] <= issue_id_i;
    if (issue_hs & issue_mem_i)   mem_next_id_q <= issue_id_i;
    if ((mem_q == M_IDLE) & mem_valid_i) mem_out_id_q <= mem_next_id_q;
  end

endmodule
